// File: rtl/connect_feeder.sv
// Initiator side of the connect_module handshake: packs pooled feature bytes into
// pool_lin, holds in_vld until out_vld rises, then forwards the FC result downstream.
module connect_feeder #(
  parameter int N_BYTES = 27,
  parameter int GAP_CYC = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [N_BYTES*8-1:0] pool_lin,
  output logic                 in_vld,
  input  logic [7:0]           ans_reg,
  input  logic                 out_vld,
  output logic [7:0]           m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [15:0]          pic_cnt,
  output logic                 err
);

  localparam int IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_OUT   = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [GAP_W-1:0]     gap_q, gap_d, gap_inc;
  logic [TMO_W-1:0]     tmo_q, tmo_d, tmo_inc;
  logic [N_BYTES*8-1:0] pool_lin_q, pool_lin_d;
  logic                 in_vld_q, in_vld_d;
  logic                 s_ready_q, s_ready_d;
  logic [7:0]           m_data_q, m_data_d;
  logic                 m_valid_q, m_valid_d;
  logic [15:0]          pic_cnt_q, pic_cnt_d;
  logic                 err_q, err_d;
  logic                 out_vld_dly_q;
  logic                 out_vld_rise;

  assign gap_inc      = gap_q + 1'b1;
  assign tmo_inc      = tmo_q + 1'b1;
  // A level that is already high when ISSUE starts must not count as a response.
  assign out_vld_rise = out_vld && !out_vld_dly_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    tmo_d      = tmo_q;
    pool_lin_d = pool_lin_q;
    in_vld_d   = in_vld_q;
    s_ready_d  = s_ready_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    pic_cnt_d  = pic_cnt_q;
    err_d      = err_q;

    case (state_q)
      S_FILL: begin
        s_ready_d = 1'b1;
        if (s_valid && s_ready_q) begin
          for (int i = 0; i < N_BYTES; i++) begin
            if (idx_q == IDX_W'(i)) pool_lin_d[i*8 +: 8] = s_data;
          end
          if (idx_q == IDX_W'(N_BYTES - 1)) begin
            idx_d     = '0;
            s_ready_d = 1'b0;
            in_vld_d  = 1'b1;
            tmo_d     = '0;
            state_d   = S_ISSUE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_ISSUE: begin
        tmo_d = tmo_inc;
        // A response arriving on the terminal count still wins over the timeout.
        if (out_vld_rise) begin
          m_data_d  = ans_reg;
          m_valid_d = 1'b1;
          in_vld_d  = 1'b0;
          tmo_d     = '0;
          state_d   = S_OUT;
        end else if (tmo_inc == TMO_W'(TIMEOUT)) begin
          err_d     = 1'b1;
          m_data_d  = 8'h80;
          m_valid_d = 1'b1;
          in_vld_d  = 1'b0;
          tmo_d     = '0;
          state_d   = S_OUT;
        end
      end
      S_OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          pic_cnt_d = pic_cnt_q + 16'd1;
          gap_d     = '0;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        // Only cycles with out_vld low count towards the inter-picture gap.
        if (out_vld) begin
          gap_d = '0;
        end else if (gap_inc == GAP_W'(GAP_CYC)) begin
          gap_d     = '0;
          s_ready_d = 1'b1;
          state_d   = S_FILL;
        end else begin
          gap_d = gap_inc;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FILL;
      idx_q         <= '0;
      gap_q         <= '0;
      tmo_q         <= '0;
      pool_lin_q    <= '0;
      in_vld_q      <= 1'b0;
      s_ready_q     <= 1'b0;
      m_data_q      <= 8'h00;
      m_valid_q     <= 1'b0;
      pic_cnt_q     <= 16'd0;
      err_q         <= 1'b0;
      out_vld_dly_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      gap_q         <= gap_d;
      tmo_q         <= tmo_d;
      pool_lin_q    <= pool_lin_d;
      in_vld_q      <= in_vld_d;
      s_ready_q     <= s_ready_d;
      m_data_q      <= m_data_d;
      m_valid_q     <= m_valid_d;
      pic_cnt_q     <= pic_cnt_d;
      err_q         <= err_d;
      out_vld_dly_q <= out_vld;
    end
  end

  assign s_ready  = s_ready_q;
  assign pool_lin = pool_lin_q;
  assign in_vld   = in_vld_q;
  assign m_data   = m_data_q;
  assign m_valid  = m_valid_q;
  assign pic_cnt  = pic_cnt_q;
  assign err      = err_q;

endmodule
